// File: rtl/injector_req_scheduler.sv
// injector_req_scheduler: round-robin arbiter that shares one endpoint packet
// injector among NREQ requesters. The winning request's fields are latched at
// grant time. The scheduler waits for the target VC to be ready, then issues a
// single-cycle write and acknowledges the requester. One gap cycle follows each
// write. A sticky timeout flag and a free-running sent-packet counter are kept
// for status.
module injector_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int V       = 2,
  parameter int Vw      = 1,
  parameter int EAw     = 4,
  parameter int DATA_W  = 128,
  parameter int SIZE_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*EAw-1:0]      req_dest,
  input  logic [NREQ*SIZE_W-1:0]   req_size,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*Vw-1:0]       req_vc,
  output logic [NREQ-1:0]          req_ack,
  input  logic [V-1:0]             inj_ready,
  output logic                     inj_pck_wr,
  output logic [EAw-1:0]           inj_endp_addr,
  output logic [SIZE_W-1:0]        inj_size,
  output logic [DATA_W-1:0]        inj_data,
  output logic [V-1:0]             inj_vc,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [31:0]              sent_cnt
);

  localparam int NREQw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTw  = $clog2(TIMEOUT);
  localparam logic [CNTw-1:0] WAIT_MAX = CNTw'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NREQw-1:0]  last_grant_q, last_grant_d;
  logic [CNTw-1:0]   wait_cnt_q, wait_cnt_d;
  logic [EAw-1:0]    inj_endp_addr_q, inj_endp_addr_d;
  logic [SIZE_W-1:0] inj_size_q, inj_size_d;
  logic [DATA_W-1:0] inj_data_q, inj_data_d;
  logic [V-1:0]      inj_vc_q, inj_vc_d;
  logic              inj_pck_wr_q, inj_pck_wr_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;
  logic [31:0]       sent_cnt_q, sent_cnt_d;

  logic              grant_found;
  logic [NREQw-1:0]  grant_idx;
  logic [NREQw-1:0]  cand;
  logic [EAw-1:0]    sel_dest;
  logic [SIZE_W-1:0] sel_size;
  logic [DATA_W-1:0] sel_data;
  logic [Vw-1:0]     sel_vc;
  logic [V-1:0]      sel_vc_onehot;

  // Round-robin search: first set req bit starting just above the last grant.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = NREQw'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the granted requester's fields and decode its VC to one-hot.
  // Out-of-range VC numbers fall back to VC 0.
  always_comb begin
    sel_dest      = '0;
    sel_size      = '0;
    sel_data      = '0;
    sel_vc        = '0;
    sel_vc_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (NREQw'(i) == grant_idx) begin
        sel_dest = req_dest[i*EAw +: EAw];
        sel_size = req_size[i*SIZE_W +: SIZE_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_vc   = req_vc[i*Vw +: Vw];
      end
    end
    for (int v = 0; v < V; v++) begin
      if (int'(sel_vc) == v) sel_vc_onehot[v] = 1'b1;
    end
    if (int'(sel_vc) >= V) sel_vc_onehot[0] = 1'b1;
  end

  // Scheduler FSM: grant, wait for VC ready, issue one write, then one gap cycle.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wait_cnt_d      = (state_q == S_WAIT) ? wait_cnt_q : '0;
    inj_endp_addr_d = inj_endp_addr_q;
    inj_size_d      = inj_size_q;
    inj_data_d      = inj_data_q;
    inj_vc_d        = inj_vc_q;
    inj_pck_wr_d    = 1'b0;
    req_ack_d       = '0;
    err_timeout_d   = err_timeout_q;
    sent_cnt_d      = sent_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          last_grant_d    = grant_idx;
          inj_endp_addr_d = sel_dest;
          inj_size_d      = sel_size;
          inj_data_d      = sel_data;
          inj_vc_d        = sel_vc_onehot;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (|(inj_ready & inj_vc_q)) begin
          inj_pck_wr_d = 1'b1;
          req_ack_d    = NREQ'(1) << last_grant_q;
          state_d      = S_ISSUE;
        end else if (wait_cnt_q == WAIT_MAX) begin
          // Counter saturates here; the stall flag stays set until reset.
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        sent_cnt_d = sent_cnt_q + 32'd1;
        state_d    = S_GAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything and aims the
  // round-robin pointer so requester 0 wins first.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      last_grant_q    <= NREQw'(NREQ - 1);
      wait_cnt_q      <= '0;
      inj_endp_addr_q <= '0;
      inj_size_q      <= '0;
      inj_data_q      <= '0;
      inj_vc_q        <= '0;
      inj_pck_wr_q    <= 1'b0;
      req_ack_q       <= '0;
      busy_q          <= 1'b0;
      err_timeout_q   <= 1'b0;
      sent_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wait_cnt_q      <= wait_cnt_d;
      inj_endp_addr_q <= inj_endp_addr_d;
      inj_size_q      <= inj_size_d;
      inj_data_q      <= inj_data_d;
      inj_vc_q        <= inj_vc_d;
      inj_pck_wr_q    <= inj_pck_wr_d;
      req_ack_q       <= req_ack_d;
      busy_q          <= busy_d;
      err_timeout_q   <= err_timeout_d;
      sent_cnt_q      <= sent_cnt_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign inj_pck_wr    = inj_pck_wr_q;
  assign inj_endp_addr = inj_endp_addr_q;
  assign inj_size      = inj_size_q;
  assign inj_data      = inj_data_q;
  assign inj_vc        = inj_vc_q;
  assign busy          = busy_q;
  assign err_timeout   = err_timeout_q;
  assign sent_cnt      = sent_cnt_q;

endmodule

// File: tb/tb_injector_req_scheduler.sv
// Testbench for injector_req_scheduler: directed scenarios plus randomized
// traffic. A transaction-level reference model predicts each write (who,
// which fields, which cycle). A monitor compares every write, ack, busy and
// timeout observation against those predictions.
module tb_injector_req_scheduler;

  localparam int NREQ    = 4;
  localparam int V       = 2;
  localparam int Vw      = 2;
  localparam int EAw     = 4;
  localparam int DATA_W  = 128;
  localparam int SIZE_W  = 5;
  localparam int TIMEOUT = 8;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*EAw-1:0]    req_dest;
  logic [NREQ*SIZE_W-1:0] req_size;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*Vw-1:0]     req_vc;
  logic [NREQ-1:0]        req_ack;
  logic [V-1:0]           inj_ready;
  logic                   inj_pck_wr;
  logic [EAw-1:0]         inj_endp_addr;
  logic [SIZE_W-1:0]      inj_size;
  logic [DATA_W-1:0]      inj_data;
  logic [V-1:0]           inj_vc;
  logic                   busy;
  logic                   err_timeout;
  logic [31:0]            sent_cnt;

  injector_req_scheduler #(
    .NREQ(NREQ), .V(V), .Vw(Vw), .EAw(EAw), .DATA_W(DATA_W),
    .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest),
    .req_size(req_size), .req_data(req_data), .req_vc(req_vc),
    .req_ack(req_ack), .inj_ready(inj_ready), .inj_pck_wr(inj_pck_wr),
    .inj_endp_addr(inj_endp_addr), .inj_size(inj_size), .inj_data(inj_data),
    .inj_vc(inj_vc), .busy(busy), .err_timeout(err_timeout), .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                idx;
    logic [EAw-1:0]    dest;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] data;
    logic [V-1:0]      vc;
    int                vci;
    longint            cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  longint cyc_cnt = 0;
  bit     m_wait, m_err, m_busy;
  int     m_rec, m_last, m_wcnt;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // One scheduler "transaction" at a time: a grant snapshots the winner,
  // the packet goes out the cycle after its VC is seen ready, and two more
  // cycles pass before the next grant can happen.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wait = 0; m_rec = 0; m_last = NREQ - 1; m_err = 0; m_wcnt = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      if (m_wait) begin
        if (inj_ready[cur.vci]) begin
          m_wait  = 0;
          m_rec   = 2;
          cur.cyc = cyc_cnt + 1;
          exp_q.push_back(cur);
        end else begin
          m_wcnt++;
          if (m_wcnt >= TIMEOUT) m_err = 1;
        end
      end else if (m_rec > 0) begin
        m_rec--;
      end else if (req != '0) begin
        int w;
        w = m_last;
        for (int k = 1; k <= NREQ; k++) begin
          w = (m_last + k) % NREQ;
          if (req[w]) break;
        end
        m_last   = w;
        cur.idx  = w;
        cur.dest = req_dest[w*EAw +: EAw];
        cur.size = req_size[w*SIZE_W +: SIZE_W];
        cur.data = req_data[w*DATA_W +: DATA_W];
        cur.vci  = int'(req_vc[w*Vw +: Vw]);
        if (cur.vci >= V) cur.vci = 0;
        cur.vc   = V'(1) << cur.vci;
        cur.cyc  = 0;
        m_wait   = 1;
        m_wcnt   = 0;
      end
      m_busy = m_wait || (m_rec > 0);
    end
  end

  // ---------------- monitor ----------------
  int     n_sent;
  bit     prev_wr, sent_pending;
  int     ack_idx_log[$];
  longint ack_cyc_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      n_sent = 0; prev_wr = 0; sent_pending = 0;
    end else begin
      check("busy", busy, m_busy);
      check("err_timeout", err_timeout, m_err);
      if (sent_pending) begin
        check("sent_cnt", sent_cnt, n_sent);
        sent_pending = 0;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
        check("missed_wr_cycle", cyc_cnt, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (inj_pck_wr) begin
        check("wr_back_to_back", prev_wr, 0);
        for (int i = 0; i < NREQ; i++)
          if (req_ack[i]) begin
            ack_idx_log.push_back(i);
            ack_cyc_log.push_back(cyc_cnt);
          end
        if (exp_q.size() == 0) begin
          check("unexpected_wr", inj_pck_wr, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_cycle", cyc_cnt, e.cyc);
          check("req_ack", req_ack, NREQ'(1) << e.idx);
          check("inj_endp_addr", inj_endp_addr, e.dest);
          check("inj_size", inj_size, e.size);
          check("inj_data", inj_data, e.data);
          check("inj_vc", inj_vc, e.vc);
          n_sent++;
          sent_pending = 1;
        end
      end else begin
        check("req_ack_idle", req_ack, 0);
      end
      prev_wr = inj_pck_wr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_dest[i*EAw +: EAw]       = EAw'($urandom);
      req_size[i*SIZE_W +: SIZE_W] = SIZE_W'($urandom);
      req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
      req_vc[i*Vw +: Vw]           = Vw'($urandom);
    end
  endtask

  task automatic apply_reset();
    req = '0;
    #1 reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  logic [DATA_W-1:0] d_grant;
  int                exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b0;
    req       = '1;
    inj_ready = '1;
    rand_fields();
    repeat (3) step();
    check("rst_inj_pck_wr", inj_pck_wr, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    check("rst_inj_fields", {inj_endp_addr, inj_size, inj_vc}, 0);
    check("rst_inj_data", inj_data, 0);

    // Fairness: all four requesting continuously, ready high.
    reset = 1'b1;
    repeat (19) step();
    req = '0;
    check("fair_sent_cnt", sent_cnt, 5);
    repeat (2) step();
    check("fair_ack_count", ack_idx_log.size() >= 5, 1);
    if (ack_idx_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("fair_order", ack_idx_log[i], exp_order[i]);
        if (i > 0) check("fair_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 4);
      end
    end

    // Single request from requester 2 on VC 1.
    apply_reset();
    req_dest[2*EAw +: EAw]       = 4'd5;
    req_size[2*SIZE_W +: SIZE_W] = 5'd7;
    req_vc[2*Vw +: Vw]           = 2'd1;
    inj_ready = 2'b10;
    req       = 4'b0100;
    step();
    step();
    check("single_wr", inj_pck_wr, 1);
    check("single_dest", inj_endp_addr, 5);
    check("single_size", inj_size, 7);
    check("single_vc", inj_vc, 2'b10);
    check("single_ack", req_ack, 4'b0100);
    req = '0;
    repeat (2) step();
    check("single_sent_cnt", sent_cnt, 1);

    // Backpressure / timeout, plus field change after grant.
    apply_reset();
    inj_ready          = '0;
    req_vc[0 +: Vw]    = 2'd0;
    d_grant            = {$urandom, $urandom, $urandom, $urandom};
    req_data[0 +: DATA_W] = d_grant;
    req                = 4'b0001;
    step();
    req_data[0 +: DATA_W] = ~d_grant;
    repeat (19) step();
    check("to_err_set", err_timeout, 1);
    check("to_no_write", sent_cnt, 0);
    inj_ready = 2'b01;
    req       = '0;
    repeat (4) step();
    check("to_err_sticky", err_timeout, 1);
    check("to_one_write", sent_cnt, 1);
    check("to_data_held", inj_data, d_grant);

    // Reset while waiting: everything drops at once, no late ack.
    apply_reset();
    inj_ready = '0;
    req       = 4'b0010;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr", inj_pck_wr, 0);
    check("midrst_ack", req_ack, 0);
    check("midrst_err", err_timeout, 0);
    step();
    req       = '0;
    inj_ready = '1;
    reset     = 1'b1;
    repeat (6) step();
    check("midrst_no_send", sent_cnt, 0);

    // Random traffic: requests toggle, fields churn every cycle, ready flickers.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 9) < 3) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 9) == 0) req[i] = 1'b0;
      end
      rand_fields();
      if ($urandom_range(0, 9) < 7) inj_ready = '1;
      else inj_ready = V'($urandom);
      if (c >= 300 && c < 340) inj_ready = '0;
      step();
    end

    req       = '0;
    inj_ready = '1;
    repeat (12) step();
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/injector_req_scheduler.md
# injector_req_scheduler

Round-robin scheduler that shares a single endpoint packet injector port among NREQ local traffic requesters. It latches the winning request, waits for the injector to report ready on the requested virtual channel, issues a single-cycle packet write, and acknowledges the requester. It sits between endpoint traffic sources and the injector's `pck_injct_in` / `pck_injct_out` control interface. It also provides a timeout flag and a sent-packet counter for testbench and status use.

## Interface
- NREQ, 4, number of requesters (2..16); NREQw = log2(NREQ)
- V, 2, virtual channels; injector ready vector width
- Vw, 1, VC index width
- EAw, 4, endpoint address width
- DATA_W, 128, packet data width
- SIZE_W, 5, packet size width
- TIMEOUT, 1024, wait cycles before flagging a stall (≥2)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; level, held until ack
- req_dest  in  NREQ*EAw  destination endpoint address per requester
- req_size  in  NREQ*SIZE_W  packet size (flits) per requester
- req_data  in  NREQ*DATA_W  packet data per requester
- req_vc  in  NREQ*Vw  requested VC per requester
- req_ack  out  NREQ  one-hot, one-cycle pulse when the packet is written
- inj_ready  in  V  injector ready per VC
- inj_pck_wr  out  1  one-cycle packet write strobe
- inj_endp_addr  out  EAw  latched destination
- inj_size  out  SIZE_W  latched size
- inj_data  out  DATA_W  latched data
- inj_vc  out  V  one-hot VC, decoded from latched req_vc
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky stall flag
- sent_cnt  out  32  packets issued; wraps

## Operation
- FSM states: IDLE, WAIT, ISSUE, GAP. All outputs are registered.
- IDLE
  - If any `req` bit is set, grant the first set bit searching upward from `last_grant+1` mod NREQ.
  - Latch that requester's dest, size, data and vc into the `inj_*` registers.
  - Set `last_grant` to the granted index; go to WAIT.
- WAIT
  - If `inj_ready[latched vc]` is 1, go to ISSUE.
  - Otherwise increment `wait_cnt`. When `wait_cnt` reaches TIMEOUT-1, set `err_timeout` and keep waiting. `wait_cnt` saturates.
- ISSUE
  - `inj_pck_wr`=1 and `req_ack[granted]`=1 for exactly this cycle.
  - Increment `sent_cnt`; go to GAP.
- GAP
  - One idle cycle so the injector can update `ready`; go to IDLE.
  - `wait_cnt` clears on entry to IDLE.
- Fields are sampled only at grant. Changes to `req_*` after grant are ignored.
- Deasserting `req` after grant does not abort: the packet is still sent and acked.
- A requester whose request is acked may re-raise `req` in the ack cycle or later. Its next grant follows the round-robin order.
- A `req_vc` value ≥ V selects VC 0.
- `err_timeout` is cleared only by reset.
- Reset, including mid-operation: state goes to IDLE immediately (asynchronously). All outputs go to 0: `inj_pck_wr`, `req_ack`, `inj_*`, `busy`, `err_timeout`, `sent_cnt`. `last_grant` is set to NREQ-1, so requester 0 wins first.

## Timing
- `req` seen in IDLE at edge n: state is WAIT and `inj_*` are valid after edge n.
- If `inj_ready` is already high, state is ISSUE after edge n+1. `inj_pck_wr` and `req_ack` are high in cycle n+1..n+2.
- Minimum request-to-write latency: 2 cycles. Best-case throughput: 1 packet per 4 cycles.
- `inj_*` stay stable from WAIT through GAP.
- `inj_pck_wr` is never high in two consecutive cycles.
- Ready dropping during WAIT simply holds the FSM in WAIT. Ready during ISSUE is not re-checked.

## Test plan
- Reset: hold `reset`=0 with `req`=4'b1111 → all outputs 0, `busy`=0. Release `reset` → first `req_ack`=4'b0001, 2 cycles after the first post-reset edge.
- Single request: `req[2]`=1, dest=5, size=7, vc=1, `inj_ready`=2'b10 → `inj_pck_wr` pulse 2 cycles later with `inj_endp_addr`=5, `inj_size`=7, `inj_vc`=2'b10, `req_ack`=4'b0100, `sent_cnt`=1.
- Fairness: `req`=4'b1111 held continuously with ready high → acks in order 0,1,2,3,0, one every 4 cycles, `sent_cnt`=5.
- Backpressure/timeout: TIMEOUT=8, `inj_ready`=0 for 20 cycles → no `inj_pck_wr`, `err_timeout`=1 after the 8th WAIT cycle. Ready rises → exactly one write follows, and `err_timeout` stays 1.
- Field change after grant: change `req_data` of the granted requester in WAIT → `inj_data` keeps the grant-time value.
- Reset mid-WAIT: assert `reset`=0 while in WAIT → `busy`, `inj_pck_wr` and `req_ack` are 0 immediately. No ack is issued after release until a new grant is made.
